// File: rtl/cbus_responder.sv
// CBus memory responder: accepts one request at a time, waits LATENCY cycles,
// then streams len+1 beats of 64-bit storage with FIXED/INCR/WRAP addressing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction; a valid request is accepted here
// ST_WAIT | latency counter running down towards the first beat
// ST_BEAT | one beat per cycle, ready=1, optional byte-masked write
module cbus_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        creq_valid_i,
    input  logic        creq_is_write_i,
    input  logic [2:0]  creq_size_i,
    input  logic [31:0] creq_addr_i,
    input  logic [7:0]  creq_strobe_i,
    input  logic [63:0] creq_data_i,
    input  logic [7:0]  creq_len_i,
    input  logic [1:0]  creq_burst_i,
    output logic        cresp_ready_o,
    output logic        cresp_last_o,
    output logic [63:0] cresp_data_o
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    beat_q, beat_d;
    logic [7:0]    len_q, len_d;
    logic [1:0]    burst_q, burst_d;
    logic          wr_q, wr_d;

    logic [63:0]   mem_q [DEPTH_WORDS];

    logic [IW-1:0] idx_inc, idx_next, wrap_mask;
    logic          is_wrap, beat_live, is_last;
    logic          unused_bits;

    assign unused_bits = ^{creq_size_i, creq_addr_i[31:3+IW], creq_addr_i[2:0]};

    // WRAP only applies to power-of-two bursts of 2..16 beats; otherwise it acts as INCR
    assign is_wrap   = (burst_q == BURST_WRAP) &&
                       (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    assign wrap_mask = IW'(len_q[3:0]);
    assign idx_inc   = idx_q + 1'b1;

    always_comb begin
        idx_next = idx_inc;
        if (burst_q == BURST_FIXED) begin
            idx_next = idx_q;
        end else if (is_wrap) begin
            idx_next = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
        end
    end

    assign beat_live     = (state_q == ST_BEAT) && creq_valid_i;
    assign is_last       = (beat_q == len_q);
    assign cresp_ready_o = beat_live;
    assign cresp_last_o  = beat_live && is_last;
    assign cresp_data_o  = beat_live ? mem_q[idx_q] : 64'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        len_d   = len_q;
        burst_d = burst_q;
        wr_d    = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (creq_valid_i) begin
                    wr_d    = creq_is_write_i;
                    idx_d   = creq_addr_i[3 +: IW];
                    len_d   = creq_len_i;
                    burst_d = creq_burst_i;
                    beat_d  = 8'd0;
                    if (LATENCY == 1) begin
                        state_d = ST_BEAT;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!creq_valid_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_BEAT;
                    end
                end
            end
            ST_BEAT: begin
                if (!creq_valid_i || is_last) begin
                    state_d = ST_IDLE;
                    beat_d  = 8'd0;
                end else begin
                    beat_d = beat_q + 8'd1;
                    idx_d  = idx_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            beat_q  <= 8'd0;
            len_q   <= 8'd0;
            burst_q <= 2'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            wr_q    <= wr_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset
    always_ff @(posedge clk_i) begin
        if (beat_live && wr_q) begin
            for (int i = 0; i < 8; i++) begin
                if (creq_strobe_i[i]) begin
                    mem_q[idx_q][8*i +: 8] <= creq_data_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_responder.sv
// Directed bench for cbus_responder (LATENCY=2): writes, INCR/WRAP/FIXED reads,
// strobes, aliasing, aborts and reset during a transaction.
module tb_cbus_responder;
    localparam logic [1:0] BF = 2'd0;
    localparam logic [1:0] BI = 2'd1;
    localparam logic [1:0] BW = 2'd2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        creq_valid_i;
    logic        creq_is_write_i;
    logic [2:0]  creq_size_i;
    logic [31:0] creq_addr_i;
    logic [7:0]  creq_strobe_i;
    logic [63:0] creq_data_i;
    logic [7:0]  creq_len_i;
    logic [1:0]  creq_burst_i;
    logic        cresp_ready_o;
    logic        cresp_last_o;
    logic [63:0] cresp_data_o;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_d [16];
    logic [63:0] wdat  [16];

    cbus_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .creq_valid_i(creq_valid_i), .creq_is_write_i(creq_is_write_i),
        .creq_size_i(creq_size_i), .creq_addr_i(creq_addr_i),
        .creq_strobe_i(creq_strobe_i), .creq_data_i(creq_data_i),
        .creq_len_i(creq_len_i), .creq_burst_i(creq_burst_i),
        .cresp_ready_o(cresp_ready_o), .cresp_last_o(cresp_last_o),
        .cresp_data_o(cresp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; the next rising edge accepts the request.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [7:0] strb, input logic chk);
        creq_valid_i    = 1'b1;
        creq_is_write_i = wr;
        creq_addr_i     = addr;
        creq_len_i      = len;
        creq_burst_i    = burst;
        creq_strobe_i   = strb;
        creq_size_i     = 3'd3;
        creq_data_i     = wdat[0];
        @(negedge clk_i);
        check("wait_ready", {63'd0, cresp_ready_o}, 64'd0);
        // request fields other than valid/data/strobe must be ignored from here on
        creq_is_write_i = ~wr;
        creq_addr_i     = ~addr;
        creq_len_i      = 8'd0;
        creq_burst_i    = burst ^ 2'b11;
        creq_size_i     = 3'd0;
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge clk_i);
            check("beat_ready", {63'd0, cresp_ready_o}, 64'd1);
            check("beat_last", {63'd0, cresp_last_o}, {63'd0, (b == int'(len))});
            if (chk) check("beat_data", cresp_data_o, exp_d[b]);
            creq_data_i = wdat[b];
        end
        @(negedge clk_i);
        check("post_ready", {63'd0, cresp_ready_o}, 64'd0);
        check("post_data", cresp_data_o, 64'd0);
        creq_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        creq_valid_i = 1'b0; creq_is_write_i = 1'b0; creq_size_i = 3'd0;
        creq_addr_i = 32'd0; creq_strobe_i = 8'd0; creq_data_i = 64'd0;
        creq_len_i = 8'd0; creq_burst_i = 2'd0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {63'd0, cresp_ready_o}, 64'd0);
        check("rst_last", {63'd0, cresp_last_o}, 64'd0);
        check("rst_data", cresp_data_o, 64'd0);
        rst_ni = 1'b1;

        // preload words 0..3 and 4..7 with INCR write bursts (first accept right after reset)
        wdat[0] = 64'hA0; wdat[1] = 64'hA1; wdat[2] = 64'hA2; wdat[3] = 64'hA3;
        xfer(1'b1, 32'h0, 8'd3, BI, 8'hFF, 1'b0);
        wdat[0] = 64'hB4; wdat[1] = 64'hB5; wdat[2] = 64'hB6; wdat[3] = 64'hB7;
        xfer(1'b1, 32'h20, 8'd3, BI, 8'hFF, 1'b0);

        // single write to word 8, then read it back
        wdat[0] = 64'h1122334455667788;
        xfer(1'b1, 32'h40, 8'd0, BI, 8'hFF, 1'b0);
        exp_d[0] = 64'h1122334455667788;
        xfer(1'b0, 32'h40, 8'd0, BI, 8'hFF, 1'b1);

        exp_d[0] = 64'hA0; exp_d[1] = 64'hA1; exp_d[2] = 64'hA2; exp_d[3] = 64'hA3;
        xfer(1'b0, 32'h0, 8'd3, BI, 8'hFF, 1'b1);

        exp_d[0] = 64'hB5; exp_d[1] = 64'hB6; exp_d[2] = 64'hB7; exp_d[3] = 64'hB4;
        xfer(1'b0, 32'h28, 8'd3, BW, 8'hFF, 1'b1);

        // WRAP with 3 beats is not a legal wrap size and behaves as INCR
        exp_d[0] = 64'hB5; exp_d[1] = 64'hB6; exp_d[2] = 64'hB7;
        xfer(1'b0, 32'h28, 8'd2, BW, 8'hFF, 1'b1);

        exp_d[0] = 64'hB4; exp_d[1] = 64'hB4; exp_d[2] = 64'hB4;
        xfer(1'b0, 32'h20, 8'd2, BF, 8'hFF, 1'b1);

        // last word, then an aliased address reading across the top of storage
        wdat[0] = 64'hC3FF;
        xfer(1'b1, 32'h1FF8, 8'd0, BI, 8'hFF, 1'b0);
        exp_d[0] = 64'hC3FF; exp_d[1] = 64'hA0;
        xfer(1'b0, 32'h80001FFB, 8'd1, BI, 8'hFF, 1'b1);

        // strobe write: beat shows pre-write value, low four lanes updated
        wdat[0] = 64'h0;
        xfer(1'b1, 32'h48, 8'd0, BI, 8'hFF, 1'b0);
        wdat[0] = 64'hFFFFFFFFFFFFFFFF; exp_d[0] = 64'h0;
        xfer(1'b1, 32'h48, 8'd0, BI, 8'h0F, 1'b1);
        exp_d[0] = 64'h00000000FFFFFFFF;
        xfer(1'b0, 32'h48, 8'd0, BI, 8'hFF, 1'b1);

        // abort in BEAT: INCR len=7, valid dropped after beat 2
        creq_valid_i = 1'b1; creq_is_write_i = 1'b0; creq_addr_i = 32'h0;
        creq_len_i = 8'd7; creq_burst_i = BI; creq_strobe_i = 8'hFF;
        @(negedge clk_i);
        check("abort_wait", {63'd0, cresp_ready_o}, 64'd0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk_i);
            check("abort_beat_ready", {63'd0, cresp_ready_o}, 64'd1);
            check("abort_beat_data", cresp_data_o, 64'hA0 + 64'(b));
        end
        creq_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("abort_idle_ready", {63'd0, cresp_ready_o}, 64'd0);
        end
        exp_d[0] = 64'h1122334455667788;
        xfer(1'b0, 32'h40, 8'd0, BI, 8'hFF, 1'b1);

        // abort in WAIT of a write: word 8 must stay intact
        creq_valid_i = 1'b1; creq_is_write_i = 1'b1; creq_addr_i = 32'h40;
        creq_len_i = 8'd0; creq_data_i = 64'hDEAD; creq_strobe_i = 8'hFF;
        @(negedge clk_i);
        creq_valid_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check("wabort_ready", {63'd0, cresp_ready_o}, 64'd0);
        end
        xfer(1'b0, 32'h40, 8'd0, BI, 8'hFF, 1'b1);

        // reset asserted during a beat clears the response at once
        creq_valid_i = 1'b1; creq_is_write_i = 1'b0; creq_addr_i = 32'h40;
        creq_len_i = 8'd3; creq_burst_i = BI;
        @(negedge clk_i);
        @(negedge clk_i);
        check("prerst_data", cresp_data_o, 64'h1122334455667788);
        rst_ni = 1'b0;
        #1;
        check("midrst_ready", {63'd0, cresp_ready_o}, 64'd0);
        check("midrst_last", {63'd0, cresp_last_o}, 64'd0);
        check("midrst_data", cresp_data_o, 64'd0);
        creq_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        xfer(1'b0, 32'h40, 8'd0, BI, 8'hFF, 1'b1);
        exp_d[0] = 64'hA2; exp_d[1] = 64'hA3;
        xfer(1'b0, 32'h10, 8'd1, BI, 8'hFF, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
